// File: rtl/pcie_tlp_req_segmenter_pkg.sv
// pcie_tlp_req_segmenter_pkg: TLP request descriptor type, format/type codes and size limits
package pcie_tlp_req_segmenter_pkg;
   localparam logic [2:0] FMT_3DW_NO_DATA = 3'b000;
   localparam logic [2:0] FMT_4DW_NO_DATA = 3'b001;
   localparam logic [2:0] FMT_3DW_DATA    = 3'b010;
   localparam logic [2:0] FMT_4DW_DATA    = 3'b011;
   localparam logic [4:0] TLP_TYPE_MEM    = 5'b00000;
   localparam int MAX_TLP_BYTES = 4096;
   typedef enum logic {IDLE, SPLIT} seg_state_e;
   typedef struct packed {
      logic [2:0]  fmt;
      logic [4:0]  tlp_type;
      logic [9:0]  len_dw;
      logic [3:0]  first_be;
      logic [3:0]  last_be;
      logic [9:0]  tag;
      logic [63:0] addr;
      logic [15:0] requester_id;
      logic [12:0] bytes;
      logic        first;
      logic        last;
   } tlp_seg_desc_t;
endpackage

// File: rtl/pcie_tlp_req_segmenter_be_calc.sv
// pcie_tlp_be_calc: DW length and first/last byte enables for a byte range
module pcie_tlp_be_calc (
   input  logic [1:0]  addr_lo_i,
   input  logic [12:0] bytes_i,
   output logic [9:0]  len_dw_o,
   output logic [3:0]  first_be_o,
   output logic [3:0]  last_be_o
);
   logic [1:0] end_lo;
   logic [3:0] fbe_raw, lbe_raw;
   // a full 1024 DW payload truncates naturally to the 0 encoding
   assign len_dw_o   = 10'((14'(addr_lo_i) + 14'(bytes_i) + 14'd3) >> 2);
   assign end_lo     = addr_lo_i + bytes_i[1:0] - 2'd1;
   assign fbe_raw    = 4'hF << addr_lo_i;
   assign lbe_raw    = 4'hF >> (2'd3 - end_lo);
   assign first_be_o = (len_dw_o == 10'd1) ? (fbe_raw & lbe_raw) : fbe_raw;
   assign last_be_o  = (len_dw_o == 10'd1) ? 4'h0 : lbe_raw;
endmodule

// File: rtl/pcie_tlp_req_segmenter.sv
// pcie_tlp_req_segmenter: splits DMA commands into MPS/MRRS-bounded MemRd/MemWr descriptors
module pcie_tlp_req_segmenter
   import pcie_tlp_req_segmenter_pkg::*;
#(
   parameter int MAX_PAYLOAD_SIZE  = 128,
   parameter int MAX_READ_REQ_SIZE = 512,
   parameter int TAG_WIDTH         = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [15:0]   requester_id,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_is_read,
   input  logic [63:0]   cmd_addr,
   input  logic [12:0]   cmd_len,
   output logic          cmd_err,
   output logic          desc_valid,
   input  logic          desc_ready,
   output tlp_seg_desc_t desc
);
   seg_state_e           state_q;
   logic [63:0]          cur_addr_q, addr_d;
   logic [12:0]          rem_q, rem_d;
   logic                 is_read_q, first_q, err_q;
   logic [TAG_WIDTH-1:0] tag_q;
   logic [12:0]          limit, room, seg_bytes;
   logic                 seg_last;
   logic [9:0]           len_dw;
   logic [3:0]           first_be, last_be;

   // limits are powers of two dividing 4 KB, so the room never spans a 4 KB boundary
   assign limit     = is_read_q ? 13'(MAX_READ_REQ_SIZE) : 13'(MAX_PAYLOAD_SIZE);
   assign room      = limit - (cur_addr_q[12:0] & (limit - 13'd1));
   assign seg_bytes = (rem_q < room) ? rem_q : room;
   assign seg_last  = seg_bytes == rem_q;
   assign addr_d    = cur_addr_q + 64'(seg_bytes);
   assign rem_d     = rem_q - seg_bytes;

   pcie_tlp_be_calc u_be (
      .addr_lo_i  (cur_addr_q[1:0]),
      .bytes_i    (seg_bytes),
      .len_dw_o   (len_dw),
      .first_be_o (first_be),
      .last_be_o  (last_be)
   );

   assign cmd_ready  = state_q == IDLE;
   assign desc_valid = state_q == SPLIT;
   assign cmd_err    = err_q;

   always_comb begin
      desc.fmt          = {1'b0, ~is_read_q, cur_addr_q[63:32] != 32'd0};
      desc.tlp_type     = TLP_TYPE_MEM;
      desc.len_dw       = len_dw;
      desc.first_be     = first_be;
      desc.last_be      = last_be;
      desc.tag          = is_read_q ? 10'(tag_q) : 10'd0;
      desc.addr         = cur_addr_q;
      desc.requester_id = requester_id;
      desc.bytes        = seg_bytes;
      desc.first        = first_q;
      desc.last         = seg_last;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cur_addr_q <= '0;
         rem_q      <= '0;
         is_read_q  <= 1'b0;
         first_q    <= 1'b0;
         err_q      <= 1'b0;
         tag_q      <= '0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: if (cmd_valid) begin
               if (cmd_len == 13'd0 || cmd_len > 13'(MAX_TLP_BYTES)) begin
                  err_q <= 1'b1;
               end else begin
                  cur_addr_q <= cmd_addr;
                  rem_q      <= cmd_len;
                  is_read_q  <= cmd_is_read;
                  first_q    <= 1'b1;
                  state_q    <= SPLIT;
               end
            end
            SPLIT: if (desc_ready) begin
               cur_addr_q <= addr_d;
               rem_q      <= rem_d;
               first_q    <= 1'b0;
               if (is_read_q) tag_q <= tag_q + TAG_WIDTH'(1);
               if (seg_last) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
